// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: records every committed-PC change into a small FIFO,
// detects a core whose PC has stopped moving, and serves a one-entry-per-cycle
// read port for a debug drain.
//
// Read handshake: rd_en is a request that needs no ready. It is honoured only
// when count != 0. A pop sampled at edge N presents rd_data with a one-cycle
// rd_valid pulse after edge N. rd_data keeps its value after the pulse ends.
module pc_trace_buffer #(
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PC_WIDTH-1:0]      pc_in,
  input  logic                     trace_en,
  input  logic                     clr,
  input  logic                     rd_en,
  output logic [PC_WIDTH-1:0]      rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     halted,
  output logic [PC_WIDTH-1:0]      halt_pc,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(HALT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(HALT_CYCLES);
  localparam logic [SW-1:0] STABLE_LAST = SW'(HALT_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic                entry_q, entry_d;
  logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
  logic [SW-1:0]       stable_q, stable_d;
  logic [PC_WIDTH-1:0] halt_pc_q, halt_pc_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [PC_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [PC_WIDTH-1:0] mem [DEPTH];

  logic push;
  logic pop;
  logic wr;
  logic full;
  logic empty;

  // Trace FSM: decides when a PC is pushed and when the core counts as halted.
  // The entry flag forces the very first RECORD cycle to push regardless of
  // the stale last_pc value.
  always_comb begin
    state_d   = state_q;
    entry_d   = 1'b0;
    last_pc_d = last_pc_q;
    stable_d  = stable_q;
    halt_pc_d = halt_pc_q;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trace_en) begin
          state_d = S_RECORD;
          entry_d = 1'b1;
        end
      end
      S_RECORD: begin
        if (!trace_en) begin
          state_d = S_IDLE;
        end else if (entry_q || (pc_in != last_pc_q)) begin
          push      = 1'b1;
          last_pc_d = pc_in;
          stable_d  = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d   = S_HALTED;
          halt_pc_d = last_pc_q;
          stable_d  = STABLE_MAX;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      S_HALTED: begin
        if (!trace_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a pop frees a slot in the same cycle, so a push into a
  // full FIFO is only dropped when no pop accompanies it.
  always_comb begin
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    pop        = rd_en && !empty;
    wr         = push && (!full || pop);
    wr_ptr_d   = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q || (push && full && !pop);
    rd_valid_d = pop;
    rd_data_d  = pop ? mem[rd_ptr_q] : rd_data_q;
    count_d    = count_q;
    if (wr && !pop)      count_d = count_q + 1'b1;
    else if (!wr && pop) count_d = count_q - 1'b1;
  end

  // Control and status registers; clr behaves exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q    <= S_IDLE;
      entry_q    <= 1'b0;
      last_pc_q  <= '0;
      stable_q   <= '0;
      halt_pc_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      last_pc_q  <= last_pc_d;
      stable_q   <= stable_d;
      halt_pc_q  <= halt_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr) mem[wr_ptr_q] <= pc_in;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign halted    = (state_q == S_HALTED);
  assign halt_pc   = halt_pc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: expected read data goes into a queue
// when rd_en is issued; a negedge monitor pops and compares on rd_valid.
module tb_pc_trace_buffer;

  localparam int PC_WIDTH    = 32;
  localparam int DEPTH       = 16;
  localparam int HALT_CYCLES = 8;
  localparam int CW          = $clog2(DEPTH) + 1;

  logic                clk;
  logic                rst;
  logic [PC_WIDTH-1:0] pc_in;
  logic                trace_en;
  logic                clr;
  logic                rd_en;
  logic [PC_WIDTH-1:0] rd_data;
  logic                rd_valid;
  logic [CW-1:0]       count;
  logic                overflow;
  logic                halted;
  logic [PC_WIDTH-1:0] halt_pc;
  logic [1:0]          dbg_state;

  logic [PC_WIDTH-1:0] exp_q[$];
  int errors;
  int checks;

  pc_trace_buffer #(
    .PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .trace_en(trace_en), .clr(clr),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .halted(halted), .halt_pc(halt_pc),
    .dbg_state(dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue a read; the caller supplies the hand-computed value it must return.
  task automatic read_exp(input logic [PC_WIDTH-1:0] exp_pc);
    rd_en = 1'b1;
    exp_q.push_back(exp_pc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: got data 0x%0h expected no pulse", rd_data);
      end else begin
        logic [PC_WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; clr = 1'b0; trace_en = 1'b0; rd_en = 1'b0; pc_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("reset_count", count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_halted", halted, 0);
    check("reset_halt_pc", halt_pc, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_state", dbg_state, 0);

    // Basic record and drain
    trace_en = 1'b1; tick();
    check("record_state", dbg_state, 1);
    for (int i = 0; i < 4; i++) begin
      pc_in = PC_WIDTH'(i * 4);
      tick();
    end
    check("basic_count", count, 4);
    trace_en = 1'b0; tick();
    check("idle_state", dbg_state, 0);
    read_exp(32'h00); tick();
    read_exp(32'h04); tick();
    read_exp(32'h08); tick();
    read_exp(32'h0C); tick();
    rd_en = 1'b0; tick();
    check("basic_drained", count, 0);
    tick();
    check("rd_data_holds", rd_data, 32'h0C);

    // Halt detection
    clr = 1'b1; tick(); clr = 1'b0;
    trace_en = 1'b1; tick();
    pc_in = 32'h3C; tick();
    pc_in = 32'h40; tick();
    for (int i = 0; i < HALT_CYCLES - 1; i++) tick();
    check("halt_not_early", halted, 0);
    tick();
    check("halted", halted, 1);
    check("halt_pc", halt_pc, 32'h40);
    check("halt_state", dbg_state, 2);
    pc_in = 32'h44; tick(); tick();
    check("halt_no_push", count, 2);
    trace_en = 1'b0; tick();
    check("halt_cleared", halted, 0);
    check("halt_pc_retained", halt_pc, 32'h40);
    read_exp(32'h3C); tick();
    read_exp(32'h40); tick();
    rd_en = 1'b0; tick();

    // Overflow, then simultaneous push and pop while full
    clr = 1'b1; tick(); clr = 1'b0;
    trace_en = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin
      pc_in = PC_WIDTH'(i * 4);
      tick();
    end
    check("full_count", count, 16);
    check("overflow_set", overflow, 1);
    pc_in = 32'h100;
    read_exp(32'h00);
    tick();
    check("full_pushpop_count", count, 16);
    check("full_pushpop_overflow", overflow, 1);
    rd_en = 1'b0; trace_en = 1'b0; tick();
    for (int i = 1; i < 16; i++) begin
      read_exp(PC_WIDTH'(i * 4));
      tick();
    end
    read_exp(32'h100); tick();
    rd_en = 1'b0; tick();
    check("full_drained", count, 0);

    // Read on empty is ignored
    rd_en = 1'b1; tick();
    check("empty_read_no_valid", rd_valid, 0);
    rd_en = 1'b0; tick();

    // clr mid-readout (overflow still set from above)
    trace_en = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      pc_in = 32'h200 + PC_WIDTH'(i * 4);
      tick();
    end
    trace_en = 1'b0; tick();
    check("clr_pre_count", count, 5);
    rd_en = 1'b1; clr = 1'b1; tick();
    rd_en = 1'b0; clr = 1'b0;
    check("clr_count", count, 0);
    check("clr_rd_valid", rd_valid, 0);
    check("clr_overflow", overflow, 0);
    check("clr_state", dbg_state, 0);
    tick();

    // Interleaved push/pop wrapping pointers
    trace_en = 1'b1; tick();
    for (int i = 0; i < 40; i++) begin
      pc_in = 32'h1000 + PC_WIDTH'(i * 4);
      if (i > 0) read_exp(32'h1000 + PC_WIDTH'((i - 1) * 4));
      tick();
    end
    check("wrap_count_steady", count, 1);
    read_exp(32'h1000 + PC_WIDTH'(39 * 4)); tick();
    rd_en = 1'b0; trace_en = 1'b0; tick();
    check("wrap_count", count, 0);
    check("wrap_no_overflow", overflow, 0);

    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
